sram_mem_ctrl: RTL and testbench

//  Sequences MEM-stage accesses from the EXE/MEM pipeline register onto a 16-bit external SRAM.

---
 rtl/sram_mem_ctrl.sv | 77 +++++++
 tb/tb_sram_mem_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits 32-bit MEM-stage loads/stores into two wait-stated 16-bit SRAM accesses
module sram_mem_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic op_wr;
  logic [SRAM_AW-2:0] wa, wa_q;
  logic [31:0] data_q;
  logic busy, last, req;
  assign req  = rd_en | wr_en;
  assign busy = (state == LOW) | (state == HIGH);
  assign last = cnt == 4'(WAIT_CYCLES - 1);
  assign wa   = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
  // next state and wait-state counter
  always_comb begin
    state_nx = state;
    cnt_nx   = busy && !last ? cnt + 4'd1 : 4'd0;
    case (state)
      IDLE:    state_nx = req ? LOW : IDLE;
      LOW:     state_nx = last ? HIGH : LOW;
      HIGH:    state_nx = last ? DONE : HIGH;
      default: state_nx = IDLE;
    endcase
  end
  // state, request latch and read-data capture on the last cycle of each half
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      wa_q      <= '0;
      data_q    <= 32'd0;
      read_data <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        op_wr  <= wr_en;
        wa_q   <= wa;
        data_q <= write_data;
      end
      if (state == LOW && last && !op_wr) read_data[15:0] <= sram_dq_in;
      if (state == HIGH && last && !op_wr) read_data[31:16] <= sram_dq_in;
    end
  end
  assign ready       = (state == IDLE && !req) || state == DONE;
  assign sram_addr   = busy ? {wa_q, state == HIGH} : '0;
  assign sram_dq_out = state == LOW ? data_q[15:0] : state == HIGH ? data_q[31:16] : 16'h0;
  assign sram_dq_oe  = busy & op_wr;
  assign sram_we_n   = ~(busy & op_wr & ~last);
  assign sram_oe_n   = ~(busy & ~op_wr);
  assign sram_ce_n   = ~busy;
  assign sram_ub_n   = ~busy;
  assign sram_lb_n   = ~busy;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: directed checks of sram_mem_ctrl against a behavioural 16-bit SRAM
module tb_sram_mem_ctrl;
  logic clk, rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic ready, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic [15:0] mem [0:255] = '{default: 16'h0};
  int wcount = 0;
  int passed = 0, total = 0, cyc;
  logic saw_oe, saw_dqoe;

  sram_mem_ctrl dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM: write on each clock edge with ce_n and we_n low
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
      wcount <= wcount + 1;
    end
  assign sram_dq_in = mem[sram_addr[7:0]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; address = a; write_data = d;
    cyc = 0; saw_oe = 1'b0; saw_dqoe = 1'b0;
    #1;
    while (!ready && cyc < 50) begin
      tick;
      cyc++;
      if (!sram_oe_n) saw_oe = 1'b1;
      if (sram_dq_oe) saw_dqoe = 1'b1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    tick; tick;
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_ce_ub_lb", {sram_ce_n, sram_ub_n, sram_lb_n}, 3'b111);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_addr_dq", {sram_addr, sram_dq_out}, 0);
    rst = 1'b1;
    tick;
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
    #1;
    chk("wr_c0_ready", ready, 0);
    tick;
    chk("wr_c1_addr", sram_addr, 0);
    chk("wr_c1_dq", sram_dq_out, 16'hBEEF);
    chk("wr_c1_we_n", sram_we_n, 0);
    chk("wr_c1_oe", {sram_dq_oe, sram_oe_n, sram_ce_n}, 3'b110);
    tick;
    chk("wr_c2_addr", sram_addr, 0);
    chk("wr_c2_dq", sram_dq_out, 16'hBEEF);
    chk("wr_c2_we_n", sram_we_n, 1);
    tick;
    chk("wr_c3_addr", sram_addr, 1);
    chk("wr_c3_dq", sram_dq_out, 16'hDEAD);
    chk("wr_c3_we_n", sram_we_n, 0);
    tick;
    chk("wr_c4_we_n", sram_we_n, 1);
    chk("wr_c4_ready", ready, 0);
    tick;
    chk("wr_c5_ready", ready, 1);
    chk("wr_c5_idle", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b110);
    wr_en = 1'b0;
    tick;
    chk("wr_mem0", mem[0], 16'hBEEF);
    chk("wr_mem1", mem[1], 16'hDEAD);
    chk("wr_count", wcount, 2);
    access(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("rd_latency", cyc, 5);
    chk("rd_data", read_data, 32'hDEADBEEF);
    chk("rd_oe_n", saw_oe, 1);
    chk("rd_dq_oe", saw_dqoe, 0);
    chk("rd_no_write", wcount, 2);
    access(1'b1, 1'b0, 32'd1028, 32'h12345678);
    chk("wr2_latency", cyc, 5);
    chk("wr2_mem2", mem[2], 16'h5678);
    chk("wr2_mem3", mem[3], 16'h1234);
    chk("wr2_count", wcount, 4);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
    cyc = 0;
    #1;
    while (!ready && cyc < 50) begin tick; cyc++; end
    chk("b2b_first_latency", cyc, 5);
    address = 32'd1044; write_data = 32'h0F0FF0F0;
    tick;
    chk("b2b_second_busy", ready, 0);
    cyc = 0;
    while (!ready && cyc < 50) begin tick; cyc++; end
    chk("b2b_second_latency", cyc, 5);
    wr_en = 1'b0;
    tick;
    chk("b2b_count", wcount, 8);
    chk("b2b_mem8_9", {mem[9], mem[8]}, 32'hAAAA5555);
    chk("b2b_mem10_11", {mem[11], mem[10]}, 32'h0F0FF0F0);
    wr_en = 1'b1; address = 32'd1048; write_data = 32'h11112222;
    #1;
    tick; tick; tick;
    chk("rstmid_high_we_n", sram_we_n, 0);
    chk("rstmid_high_addr", sram_addr, 13);
    rst = 1'b0;
    #1;
    chk("rstmid_strobes", {sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 5'b11111);
    chk("rstmid_dq_oe", sram_dq_oe, 0);
    chk("rstmid_read_data", read_data, 0);
    wr_en = 1'b0;
    #1;
    chk("rstmid_ready", ready, 1);
    rst = 1'b1;
    tick; tick; tick; tick;
    chk("rstmid_ready_after", ready, 1);
    chk("rstmid_count", wcount, 9);
    chk("rstmid_mem12", mem[12], 16'h2222);
    chk("rstmid_mem13", mem[13], 16'h0);
    access(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("rd2_data", read_data, 32'hDEADBEEF);
    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    chk("both_latency", cyc, 5);
    chk("both_mem4_5", {mem[5], mem[4]}, 32'hCAFEF00D);
    chk("both_read_data", read_data, 32'hDEADBEEF);
    chk("both_dq_oe", saw_dqoe, 1);
    chk("both_oe_n", saw_oe, 0);
    chk("both_count", wcount, 11);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
